rv_enable_dff: RTL and testbench

Parameterized, clock-gated enable flip-flop bank used throughout the core for power-saving storage (e.g., the 31 x 32-bit integer GPRs in decode, one instance per register, enabled by that register's write strobe). Captures `din` on the rising clock edge only when enabled; otherwise holds. The clock to the storage is gated by a glitch-free integrated clock gate (ICG) built inside the block, unless the mux-based implementation is selected.

---
 rtl/rv_enable_dff.sv | 60 ++++++
 tb/tb_rv_enable_dff.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rv_enable_dff.sv
// rv_enable_dff: enable flop bank, clocked through an internal glitch-free clock gate.
// Defining RV_FPGA_OPTIMIZE_EN (or setting OVERRIDE=1) selects the ungated mux form instead.
module rv_enable_dff #(
    parameter int WIDTH    = 1,
    parameter bit OVERRIDE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             scan_mode,
    output logic [WIDTH-1:0] dout
);

    logic en_eff;

    assign en_eff = en | scan_mode;

`ifdef RV_FPGA_OPTIMIZE_EN
    localparam bit USE_MUX = 1'b1 | OVERRIDE;
`else
    localparam bit USE_MUX = OVERRIDE;
`endif

    generate
        if (USE_MUX) begin : g_mux
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    dout <= '0;
                end else begin
                    dout <= en_eff ? din : dout;
                end
            end
        end else begin : g_icg
            logic en_latched;
            logic gated_clk;

            // Latch is transparent only while clk is low, so enable changes
            // during the high phase can never produce a pulse on gated_clk.
            always_latch begin
                if (!rst_l) begin
                    en_latched = 1'b0;
                end else if (!clk) begin
                    en_latched = en_eff;
                end
            end

            assign gated_clk = clk & en_latched;

            always_ff @(posedge gated_clk or negedge rst_l) begin
                if (!rst_l) begin
                    dout <= '0;
                end else begin
                    dout <= din;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rv_enable_dff.sv
// Scoreboard bench for rv_enable_dff: gated and mux builds driven in parallel.
module tb_rv_enable_dff;
    localparam int W = 32;

    typedef struct {
        string      tag;
        logic [W-1:0] value;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_l;
    logic         en;
    logic         scan_mode;
    logic [W-1:0] din;
    logic [W-1:0] dout_gated;
    logic [W-1:0] dout_mux;

    int checks   = 0;
    int failures = 0;

    exp_t         exp_q[$];
    logic [W-1:0] model_value;

    always #5 clk = ~clk;

    rv_enable_dff #(.WIDTH(W), .OVERRIDE(1'b0)) dut_gated (
        .clk(clk), .rst_l(rst_l), .en(en), .din(din),
        .scan_mode(scan_mode), .dout(dout_gated)
    );

    rv_enable_dff #(.WIDTH(W), .OVERRIDE(1'b1)) dut_mux (
        .clk(clk), .rst_l(rst_l), .en(en), .din(din),
        .scan_mode(scan_mode), .dout(dout_mux)
    );

    task automatic checkValue(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: dout=%h expected=%h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] required);
        checkValue({name, "/gated"}, dout_gated, required);
        checkValue({name, "/mux"}, dout_mux, required);
    endtask

    // Drive on the falling edge; at the rising edge the model decides what dout must become.
    task automatic applyStimulus(input string tag, input logic r, input logic e,
                                 input logic s, input logic [W-1:0] d);
        exp_t item;
        @(negedge clk);
        rst_l     = r;
        en        = e;
        scan_mode = s;
        din       = d;
        @(posedge clk);
        if (!rst_l)
            model_value = '0;
        else if (en || scan_mode)
            model_value = din;
        item.tag   = tag;
        item.value = model_value;
        exp_q.push_back(item);
    endtask

    initial begin : monitor
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                checkOutput(item.tag, item.value);
            end
        end
    end

    initial begin : stimulus
        rst_l       = 1'b0;
        en          = 1'b1;
        scan_mode   = 1'b0;
        din         = 32'hFFFF_FFFF;
        model_value = '0;

        #2;
        checkOutput("reset_imm", 32'h0);
        applyStimulus("reset_hold", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        applyStimulus("reset_hold", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        applyStimulus("reset_release", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);

        applyStimulus("load", 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++)
            applyStimulus("hold", 1'b1, 1'b0, 1'b0, 32'h1234_5678);

        for (int i = 1; i <= 3; i++)
            applyStimulus("b2b", 1'b1, 1'b1, 1'b0, W'(i));

        applyStimulus("scan", 1'b1, 1'b0, 1'b1, 32'hA5A5_A5A5);
        applyStimulus("scan_off", 1'b1, 1'b0, 1'b0, 32'h0000_0077);

        // Pulse en only while clk is high; the latch must keep the gate shut.
        #2;
        din = 32'hCAFE_F00D;
        en  = 1'b1;
        #1;
        en  = 1'b0;
        #1;
        checkOutput("glitch_high", 32'hA5A5_A5A5);
        applyStimulus("glitch_edge", 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);

        applyStimulus("pre_async", 1'b1, 1'b1, 1'b0, 32'h0000_0005);
        @(negedge clk);
        en  = 1'b1;
        din = 32'h0000_0005;
        #2;
        rst_l       = 1'b0;
        model_value = '0;
        #1;
        checkOutput("async_rst", 32'h0);
        applyStimulus("rst_wins", 1'b0, 1'b1, 1'b0, 32'h0000_0005);
        applyStimulus("post_rst", 1'b1, 1'b1, 1'b0, 32'h0000_0009);

        for (int i = 0; i < 300; i++)
            applyStimulus("random", ($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), W'($urandom));

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
